data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/dmem_pkg.sv | 53 +++++
 rtl/load_align.sv | 25 ++
 rtl/data_mem_ctrl.sv | 161 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory controller.
package dmem_pkg;

  // Access size encodings; the unused code 2'd3 behaves as a word.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Controller FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  // A half must sit on an even byte; a word on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  // Byte-lane write strobes for an aligned store.
  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] strb;
    strb = 4'b1111;
    case (size)
      SZ_BYTE: strb = 4'b0001 << off;
      SZ_HALF: strb = 4'b0011 << {off[1], 1'b0};
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Replicate right-aligned store data across every lane it could land in.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] rep;
    rep = data;
    case (size)
      SZ_BYTE: rep = {4{data[7:0]}};
      SZ_HALF: rep = {2{data[15:0]}};
      default: rep = data;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed lane of a read word and sign/zero-extends it.
module load_align
  import dmem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  // Extend the low byte/half of the shifted word according to size and signedness.
  always_comb begin
    case (size_i)
      SZ_BYTE: result_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: result_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      default: result_o = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store unit bridge: one outstanding access to a ready/valid data bus.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_read_en,
  input  logic        i_write_en,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_rdata,
  output logic        o_stall,
  output logic        o_misaligned,
  output logic        o_bus_error,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  output logic        o_mem_we,
  input  logic        i_mem_rsp_valid,
  input  logic [31:0] i_mem_rdata
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [CW-1:0] cnt_inc;
  logic          timeout;
  logic [31:0]   ld_data;

  assign cnt_inc = cnt_q + CW'(1);
  assign timeout = (cnt_inc == CNT_MAX);

  load_align u_load_align (
    .rdata_i   (rdata_q),
    .offset_i  (addr_q[1:0]),
    .size_i    (size_q),
    .unsigned_i(unsigned_q),
    .result_o  (ld_data)
  );

  // State register and transaction registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: every register here is a plain flop (no memory array), so all of them take the reset.
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      we_q       <= we_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Next-state, register updates and all outputs for the access FSM.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    size_d          = size_q;
    unsigned_d      = unsigned_q;
    we_d            = we_q;
    rdata_d         = rdata_q;
    cnt_d           = cnt_q;
    err_d           = err_q;
    o_rdata         = '0;
    o_stall         = 1'b0;
    o_misaligned    = 1'b0;
    o_bus_error     = 1'b0;
    o_mem_req_valid = 1'b0;
    o_mem_addr      = '0;
    o_mem_wdata     = '0;
    o_mem_wstrb     = '0;
    o_mem_we        = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_read_en || i_write_en) begin
          if (is_misaligned(i_size, i_addr[1:0])) begin
            o_misaligned = 1'b1;
          end else begin
            o_stall    = 1'b1;
            addr_d     = i_addr;
            wdata_d    = i_wdata;
            size_d     = i_size;
            unsigned_d = i_unsigned;
            we_d       = i_write_en;
            rdata_d    = '0;
            cnt_d      = '0;
            err_d      = 1'b0;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        o_stall         = 1'b1;
        o_mem_req_valid = 1'b1;
        o_mem_addr      = {addr_q[31:2], 2'b00};
        o_mem_we        = we_q;
        o_mem_wstrb     = we_q ? store_strb(size_q, addr_q[1:0]) : 4'b0000;
        o_mem_wdata     = we_q ? store_data(size_q, wdata_q) : '0;
        cnt_d           = cnt_inc;
        if (timeout) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (i_mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        o_stall = 1'b1;
        cnt_d   = cnt_inc;
        // A real response in the final cycle still beats the timeout.
        if (i_mem_rsp_valid) begin
          rdata_d = i_mem_rdata;
          state_d = DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        o_bus_error = err_q;
        o_rdata     = (we_q || err_q) ? '0 : ld_data;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl with a behavioural byte-lane model.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr, i_wdata, i_mem_rdata;
  logic        i_read_en, i_write_en, i_unsigned, i_mem_req_ready, i_mem_rsp_valid;
  logic [1:0]  i_size;
  logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
  logic        o_stall, o_misaligned, o_bus_error, o_mem_req_valid, o_mem_we;
  logic [3:0]  o_mem_wstrb;

  // Second instance with a short timeout, sharing address/data/size inputs.
  logic        t_read_en, t_ready, t_rsp_valid;
  logic [31:0] t_rdata, t_mem_addr, t_mem_wdata;
  logic        t_stall, t_misaligned, t_bus_error, t_req_valid, t_we;
  logic [3:0]  t_wstrb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_ctrl dut (
    .clk(clk), .rst(rst), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_read_en(i_read_en), .i_write_en(i_write_en), .i_size(i_size), .i_unsigned(i_unsigned),
    .o_rdata(o_rdata), .o_stall(o_stall), .o_misaligned(o_misaligned), .o_bus_error(o_bus_error),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb), .o_mem_we(o_mem_we),
    .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rdata(i_mem_rdata)
  );

  data_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_read_en(t_read_en), .i_write_en(1'b0), .i_size(i_size), .i_unsigned(i_unsigned),
    .o_rdata(t_rdata), .o_stall(t_stall), .o_misaligned(t_misaligned), .o_bus_error(t_bus_error),
    .o_mem_req_valid(t_req_valid), .i_mem_req_ready(t_ready),
    .o_mem_addr(t_mem_addr), .o_mem_wdata(t_mem_wdata), .o_mem_wstrb(t_wstrb), .o_mem_we(t_we),
    .i_mem_rsp_valid(t_rsp_valid), .i_mem_rdata(32'hDEAD_BEEF)
  );

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [1:0] size, input logic uns);
    longint unsigned v;
    int bits;
    bits = 8 * nbytes(size);
    v = longint'(word) >> (8 * int'(addr[1:0]));
    v = v % (64'd1 << bits);
    if (!uns && ((v >> (bits - 1)) & 64'd1) == 64'd1) v = v + (64'hFFFF_FFFF_FFFF_FFFF << bits);
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_strb(input logic [31:0] addr, input logic [1:0] size);
    logic [3:0] s;
    int off;
    off = int'(addr[1:0]);
    for (int b = 0; b < 4; b++) s[b] = (b >= off) && (b < off + nbytes(size));
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] data, input logic [1:0] size);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = data[8*(b % nbytes(size)) +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    i_read_en = 1'b0; i_write_en = 1'b0; i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0;
    i_mem_rdata = '0; t_read_en = 1'b0; t_ready = 1'b0; t_rsp_valid = 1'b0;
  endtask

  // One complete access with given ready and response delays; inputs are scrambled meanwhile.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input logic [31:0] mem_word,
                         input int rdly, input int sdly, input string name);
    int stalls, req_n, wait_n, exp_stalls;
    bit in_wait, done;
    logic [31:0] exp_rd;
    exp_rd = wr ? 32'h0 : model_load(mem_word, addr, size, uns);
    exp_stalls = 1 + (rdly + 1) + (sdly + 1);
    @(negedge clk);
    i_read_en = ~wr; i_write_en = wr; i_addr = addr; i_wdata = wdata; i_size = size; i_unsigned = uns;
    i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if (o_stall !== 1'b1 || o_misaligned !== 1'b0 || o_mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s accept: stall=%b mis=%b req=%b, want 1 0 0", name, o_stall, o_misaligned, o_mem_req_valid);
    end
    stalls = 1; req_n = 0; wait_n = 0; in_wait = 0; done = 0;
    @(negedge clk);
    i_read_en = 1'b0; i_write_en = 1'b0; i_addr = $urandom; i_wdata = $urandom;
    i_size = 2'($urandom); i_unsigned = 1'($urandom);
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      #1;
      if (!o_stall) begin
        done = 1;
        checks++;
        if (o_rdata !== exp_rd || o_bus_error !== 1'b0 || o_mem_req_valid !== 1'b0) begin
          failures++;
          $display("FAIL %s done: rdata=%h berr=%b req=%b, want %h 0 0", name, o_rdata, o_bus_error, o_mem_req_valid, exp_rd);
        end
        checks++;
        if (stalls != exp_stalls) begin
          failures++;
          $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, exp_stalls);
        end
        i_mem_rsp_valid = 1'b0; i_mem_req_ready = 1'b0;
      end else begin
        stalls++;
        if (!in_wait) begin
          checks++;
          if (o_mem_req_valid !== 1'b1 || o_mem_addr !== {addr[31:2], 2'b00} || o_mem_we !== wr ||
              o_mem_wstrb !== (wr ? model_strb(addr, size) : 4'b0000) ||
              (wr && o_mem_wdata !== model_wdata(wdata, size))) begin
            failures++;
            $display("FAIL %s req: valid=%b addr=%h we=%b strb=%b wdata=%h, want 1 %h %b %b %h", name,
                     o_mem_req_valid, o_mem_addr, o_mem_we, o_mem_wstrb, o_mem_wdata,
                     {addr[31:2], 2'b00}, wr, wr ? model_strb(addr, size) : 4'b0000, model_wdata(wdata, size));
          end
          i_mem_req_ready = (req_n >= rdly);
          i_mem_rsp_valid = 1'($urandom);   // stray responses outside WAIT must be ignored
          i_mem_rdata = $urandom;
          if (i_mem_req_ready) in_wait = 1;
          req_n++;
        end else begin
          checks++;
          if (o_mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s wait_req: req_valid=%b want 0", name, o_mem_req_valid);
          end
          i_mem_req_ready = 1'($urandom);
          i_mem_rsp_valid = (wait_n >= sdly);
          i_mem_rdata = i_mem_rsp_valid ? mem_word : $urandom;
          wait_n++;
        end
      end
      if (!done) @(negedge clk);
    end
    if (!done) begin
      failures++;
      $display("FAIL %s timeout: never left stall", name);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    i_addr = '0; i_wdata = '0; i_size = '0; i_unsigned = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({o_rdata, o_stall, o_misaligned, o_bus_error, o_mem_req_valid, o_mem_addr, o_mem_wdata,
         o_mem_wstrb, o_mem_we} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: rdata=%h stall=%b mis=%b berr=%b req=%b addr=%h, want all 0",
               o_rdata, o_stall, o_misaligned, o_bus_error, o_mem_req_valid, o_mem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_txn(1'b0, 32'h0000_0103, 32'h0, 2'd0, 1'b0, 32'h80FF_1234, 0, 0, "lb_0x103");
    run_txn(1'b1, 32'h0000_0202, 32'h0000_ABCD, 2'd1, 1'b0, 32'h0, 0, 0, "sh_0x202");
    run_txn(1'b0, 32'h0000_0400, 32'h0, 2'd2, 1'b0, 32'h1234_5678, 5, 1, "lw_ready_late");
    run_txn(1'b0, 32'h0000_0502, 32'h0, 2'd1, 1'b1, 32'h8001_7FFF, 0, 2, "lhu_0x502");
    run_txn(1'b1, 32'h0000_0600, 32'hCAFE_F00D, 2'd3, 1'b0, 32'h0, 1, 0, "sw_size3");
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [4] = '{32'h0000_0101, 32'h0000_0203, 32'h0000_0302, 32'h0000_0401};
    logic [1:0]  sizes [4] = '{2'd2, 2'd1, 2'd3, 2'd1};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      i_addr = addrs[k]; i_size = sizes[k]; i_read_en = (k != 3); i_write_en = (k == 3);
      for (int c = 0; c < 3; c++) begin
        #1;
        checks++;
        if (o_misaligned !== 1'b1 || o_stall !== 1'b0 || o_mem_req_valid !== 1'b0) begin
          failures++;
          $display("FAIL misaligned_%0d: mis=%b stall=%b req=%b, want 1 0 0", k, o_misaligned, o_stall, o_mem_req_valid);
        end
        @(negedge clk);
      end
      i_read_en = 1'b0; i_write_en = 1'b0;
      #1;
      checks++;
      if (o_misaligned !== 1'b0 || o_mem_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL misaligned_release_%0d: mis=%b req=%b, want 0 0", k, o_misaligned, o_mem_req_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom);
      a = $urandom;
      if (sz == 2'd1) a[0] = 1'b0;
      else if (sz != 2'd0) a[1:0] = 2'b00;
      run_txn(1'($urandom), a, $urandom, sz, 1'($urandom), $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_timeout();
    int pulses, stalls;
    @(negedge clk);
    i_addr = 32'h0000_0040; i_size = 2'd2; t_read_en = 1'b1; t_ready = 1'b1; t_rsp_valid = 1'b0;
    pulses = 0; stalls = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (t_stall) stalls++;
      if (t_bus_error) begin
        pulses++;
        checks++;
        if (t_rdata !== 32'h0 || t_stall !== 1'b0) begin
          failures++;
          $display("FAIL timeout_done: rdata=%h stall=%b, want 0 0", t_rdata, t_stall);
        end
      end
      @(negedge clk);
      t_read_en = 1'b0;
    end
    #1;
    checks++;
    if (pulses != 1 || stalls != 5 || t_stall !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse: pulses=%0d stalls=%0d stall_end=%b, want 1 5 0", pulses, stalls, t_stall);
    end
    t_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    i_addr = 32'h0000_0800; i_size = 2'd2; i_read_en = 1'b1; i_mem_req_ready = 1'b1;
    @(negedge clk);
    i_read_en = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (o_stall !== 1'b1 || o_mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_wait: stall=%b req=%b, want 1 0", o_stall, o_mem_req_valid);
    end
    i_mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_mem_rsp_valid = 1'b1; i_mem_rdata = 32'h5555_AAAA;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (o_stall !== 1'b0 || o_rdata !== 32'h0 || o_mem_req_valid !== 1'b0 || o_bus_error !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_late_rsp: stall=%b rdata=%h req=%b berr=%b, want 0 0 0 0",
                 o_stall, o_rdata, o_mem_req_valid, o_bus_error);
      end
      @(negedge clk);
      i_mem_rsp_valid = 1'b0;
    end
    run_txn(1'b0, 32'h0000_0804, 32'h0, 2'd2, 1'b0, 32'h0BAD_F00D, 0, 0, "lw_after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_misaligned();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
